// File: rtl/segment_write_scheduler.sv
// Write-side sequencer for the segmented DMA loopback: interleaves source
// cache lines round-robin over four segments and tracks write completions.
module segment_write_scheduler #(
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 17,
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] wr_addr_s0,
    input  logic [ADDR_WIDTH-1:0] wr_addr_s1,
    input  logic [ADDR_WIDTH-1:0] wr_addr_s2,
    input  logic [ADDR_WIDTH-1:0] wr_addr_s3,
    input  logic [SIZE_WIDTH-1:0] size,
    output logic                  done,
    output logic                  busy,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_rd_en,
    output logic                  dma_wr_en,
    output logic [ADDR_WIDTH-1:0] dma_wr_addr,
    output logic [DATA_WIDTH-1:0] dma_wr_data,
    input  logic                  dma_wr_full,
    input  logic                  dma_wr_complete
);

    localparam int CW = SIZE_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] base_q [4];
    logic [SIZE_WIDTH-1:0] size_q;
    logic [SIZE_WIDTH-1:0] line_q;
    logic [1:0]            seg_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [CW-1:0]         target;
    logic                  done_q;
    logic                  busy_q;
    logic                  fire;
    logic                  last_fire;

    assign target = {size_q, 2'b00};

    always_comb begin
        fire      = (state_q == RUN) && data_in_valid && !dma_wr_full;
        last_fire = fire && (seg_q == 2'd3)
                    && (line_q == size_q - SIZE_WIDTH'(1));
        cnt_d     = cnt_q + CW'(dma_wr_complete);
    end

    assign dma_wr_en     = fire;
    assign data_in_rd_en = fire;
    assign dma_wr_data   = data_in;
    assign dma_wr_addr   = fire
                         ? base_q[seg_q] + ADDR_WIDTH'(line_q)
                         : '0;
    assign done          = done_q;
    assign busy          = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            for (int i = 0; i < 4; i++) begin
                base_q[i] <= '0;
            end
            size_q  <= '0;
            line_q  <= '0;
            seg_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (go) begin
                        base_q[0] <= wr_addr_s0;
                        base_q[1] <= wr_addr_s1;
                        base_q[2] <= wr_addr_s2;
                        base_q[3] <= wr_addr_s3;
                        size_q    <= size;
                        line_q    <= '0;
                        seg_q     <= '0;
                        cnt_q     <= '0;
                        if (size == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= RUN;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_d;
                    if (fire) begin
                        seg_q <= seg_q + 2'd1;
                        if (seg_q == 2'd3) begin
                            line_q <= line_q + SIZE_WIDTH'(1);
                        end
                    end
                    // Final ack may land in the same cycle as the final issue
                    if (last_fire) begin
                        if (cnt_d == target) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == target) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segment_write_scheduler.sv
// Directed bench for segment_write_scheduler with a 2-cycle ack responder
// and a counting source FIFO model.
module tb_segment_write_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic [63:0]  wr_addr_s0, wr_addr_s1, wr_addr_s2, wr_addr_s3;
    logic [16:0]  size;
    logic         done, busy;
    logic [511:0] data_in;
    logic         data_in_valid;
    logic         data_in_rd_en;
    logic         dma_wr_en;
    logic [63:0]  dma_wr_addr;
    logic [511:0] dma_wr_data;
    logic         dma_wr_full;
    logic         dma_wr_complete;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    int last_cpl_edge = -1;
    int ncpl = 0;
    int viol = 0;
    logic [1:0]  pipe = 2'b00;
    logic        rand_mode = 1'b0;
    logic [31:0] data_cnt = 32'h0;

    logic [63:0]  qa [$];
    logic [511:0] qd [$];
    int           qe [$];

    always #5 clk = ~clk;

    segment_write_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .go              (go),
        .wr_addr_s0      (wr_addr_s0),
        .wr_addr_s1      (wr_addr_s1),
        .wr_addr_s2      (wr_addr_s2),
        .wr_addr_s3      (wr_addr_s3),
        .size            (size),
        .done            (done),
        .busy            (busy),
        .data_in         (data_in),
        .data_in_valid   (data_in_valid),
        .data_in_rd_en   (data_in_rd_en),
        .dma_wr_en       (dma_wr_en),
        .dma_wr_addr     (dma_wr_addr),
        .dma_wr_data     (dma_wr_data),
        .dma_wr_full     (dma_wr_full),
        .dma_wr_complete (dma_wr_complete)
    );

    assign data_in         = {16{data_cnt}};
    assign dma_wr_complete = pipe[1];

    // Ack responder (2 cycles after issue) and FIFO pop model
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        pipe     <= {pipe[0], dma_wr_en};
        if (data_in_rd_en) data_cnt <= data_cnt + 32'd1;
        if (dma_wr_complete) begin
            ncpl          <= ncpl + 1;
            last_cpl_edge <= edge_cnt;
        end
    end

    always @(negedge clk) begin
        if (dma_wr_en) begin
            qa.push_back(dma_wr_addr);
            qd.push_back(dma_wr_data);
            qe.push_back(edge_cnt);
        end
        if (dma_wr_en !== data_in_rd_en) viol <= viol + 1;
        if (dma_wr_en && (dma_wr_full || !data_in_valid)) viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            dma_wr_full   = edge_cnt[0];
            data_in_valid = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wr_en"}, dma_wr_en, 0);
        chk({tag, "_rd_en"}, data_in_rd_en, 0);
        chk({tag, "_addr"}, dma_wr_addr, 0);
    endtask

    task automatic run_case(input int sz, input bit rnd, input bit midgo);
        logic [63:0]  b [4];
        logic [31:0]  d0;
        logic [31:0]  dv;
        logic [63:0]  ea;
        int           n0;
        int           v0;
        int           nexp;
        bit           sent;
        b[0] = wr_addr_s0;
        b[1] = wr_addr_s1;
        b[2] = wr_addr_s2;
        b[3] = wr_addr_s3;
        qa.delete(); qd.delete(); qe.delete();
        d0   = data_cnt;
        n0   = ncpl;
        v0   = viol;
        nexp = 4 * sz;
        sent = 0;
        size = 17'(sz);
        rand_mode = rnd;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk($sformatf("sz%0d_busy_after_go", sz), busy, 1);
        chk($sformatf("sz%0d_done_cleared", sz), done, 0);
        for (int k = 0; k < 2000; k++) begin
            if (midgo && !sent && qa.size() >= 5) begin
                go = 1'b1;
                size = 17'd1;
                wr_addr_s0 = 64'hdead_0000;
                wr_addr_s2 = 64'hbeef_0000;
                sent = 1;
            end
            tick();
            go = 1'b0;
            if (done) break;
        end
        rand_mode     = 1'b0;
        data_in_valid = 1'b1;
        dma_wr_full   = 1'b0;
        chk($sformatf("sz%0d_done", sz), done, 1);
        chk($sformatf("sz%0d_busy_end", sz), busy, 0);
        chk($sformatf("sz%0d_nwrites", sz), qa.size(), nexp);
        chk($sformatf("sz%0d_ncpl", sz), ncpl - n0, nexp);
        chk($sformatf("sz%0d_done_edge", sz), last_cpl_edge, edge_cnt - 1);
        chk($sformatf("sz%0d_handshake", sz), viol - v0, 0);
        for (int i = 0; i < qa.size() && i < nexp; i++) begin
            ea = b[i % 4] + 64'(i / 4);
            dv = d0 + 32'(i);
            chk($sformatf("sz%0d_addr%0d", sz, i), qa[i], ea);
            chk($sformatf("sz%0d_data%0d", sz, i), qd[i], {16{dv}});
            if (!rnd)
                chk($sformatf("sz%0d_edge%0d", sz, i), qe[i], qe[0] + i);
        end
        wr_addr_s0 = b[0];
        wr_addr_s2 = b[2];
    endtask

    initial begin
        rst = 1'b0;
        go = 1'b0;
        wr_addr_s0 = 64'h100;
        wr_addr_s1 = 64'h200;
        wr_addr_s2 = 64'h300;
        wr_addr_s3 = 64'h400;
        size = 17'd0;
        data_in_valid = 1'b1;
        dma_wr_full = 1'b0;
        #2;
        chk_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();

        run_case(1, 0, 0);
        run_case(3, 0, 0);
        run_case(2, 1, 0);

        qa.delete();
        size = 17'd0;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("sz0_done", done, 1);
        chk("sz0_busy", busy, 0);
        repeat (3) tick();
        chk("sz0_nwrites", qa.size(), 0);
        chk("sz0_done_held", done, 1);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("sz0_rego_done", done, 1);
        chk("sz0_rego_nwrites", qa.size(), 0);

        run_case(4, 0, 1);

        size = 17'd4;
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (6) tick();
        chk("midrun_wr_en", dma_wr_en, 1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_wr_en", dma_wr_en, 0);

        run_case(2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
